// File: rtl/byte_op_pkg.sv
// Shared definitions for the byte-manipulation controller: opcodes, FSM encoding
// and the legality check used at issue time.
package byte_op_pkg;

    localparam int DATA_W = 16;
    localparam int RA_W   = 3;
    localparam int OP_W   = 3;
    localparam int CNT_W  = 3;

    localparam logic [OP_W-1:0] OP_MOVL  = 3'd0;
    localparam logic [OP_W-1:0] OP_MOVLZ = 3'd1;
    localparam logic [OP_W-1:0] OP_MOVLS = 3'd2;
    localparam logic [OP_W-1:0] OP_MOVH  = 3'd3;
    localparam logic [OP_W-1:0] OP_SWPB  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB    = 3'd4
    } state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_SWPB;
    endfunction

endpackage

// File: rtl/byte_op_ctrl_if.sv
// Decode request handshake plus register-file read/write ports of the controller.
interface byte_op_ctrl_if;
    import byte_op_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [RA_W-1:0]   req_dst;
    logic [7:0]        req_byte;
    logic              rf_rd_en;
    logic [RA_W-1:0]   rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_wr_req;
    logic              rf_wr_gnt;
    logic [RA_W-1:0]   rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              done;
    logic              err;

    modport slave (
        input  req_valid, req_op, req_dst, req_byte, rf_rd_data, rf_wr_gnt,
        output req_ready, rf_rd_en, rf_rd_addr, rf_wr_req, rf_wr_addr, rf_wr_data,
               done, err
    );

    modport master (
        output req_valid, req_op, req_dst, req_byte, rf_rd_data, rf_wr_gnt,
        input  req_ready, rf_rd_en, rf_rd_addr, rf_wr_req, rf_wr_addr, rf_wr_data,
               done, err
    );

endinterface

// File: rtl/byte_op_alu.sv
// Combinational byte merge/swap applied to the register value read back for Rd.
module byte_op_alu
    import byte_op_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] v,
    input  logic [7:0]        b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = v;
        case (op)
            OP_MOVL:  result = {v[15:8], b};
            OP_MOVLZ: result = {8'h00, b};
            OP_MOVLS: result = {8'hFF, b};
            OP_MOVH:  result = {b, v[7:0]};
            OP_SWPB:  result = {v[7:0], v[15:8]};
            default:  result = v;
        endcase
    end

endmodule

// File: rtl/byte_op_ctrl.sv
// Read-modify-write sequencer for one byte instruction at a time.
//   state | meaning
//   IDLE  | ready for a request
//   ISSUE | read strobe out, or drop an illegal op with err
//   WAIT  | count down read latency, capture read data at zero
//   EXEC  | register the ALU result
//   WB    | hold the write request until granted
module byte_op_ctrl
    import byte_op_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic           E,
    input  logic           rst,
    byte_op_ctrl_if.slave  bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [RA_W-1:0]   dst_q, dst_d;
    logic [7:0]        byte_q, byte_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_req_q, wr_req_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] alu_res;

    byte_op_alu u_alu (
        .op     (op_q),
        .v      (val_q),
        .b      (byte_q),
        .result (alu_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        dst_d    = dst_q;
        byte_d   = byte_q;
        val_d    = val_q;
        result_d = result_q;
        rd_en_d  = 1'b0;
        wr_req_d = wr_req_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    dst_d   = bus.req_dst;
                    byte_d  = bus.req_byte;
                    rd_en_d = op_is_legal(bus.req_op);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!op_is_legal(op_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    val_d   = bus.rf_rd_data;
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EXEC: begin
                result_d = alu_res;
                wr_req_d = 1'b1;
                state_d  = ST_WB;
            end
            ST_WB: begin
                if (bus.rf_wr_gnt) begin
                    wr_req_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge E) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            dst_q    <= '0;
            byte_q   <= '0;
            val_q    <= '0;
            result_q <= '0;
            rd_en_q  <= 1'b0;
            wr_req_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            byte_q   <= byte_d;
            val_q    <= val_d;
            result_q <= result_d;
            rd_en_q  <= rd_en_d;
            wr_req_q <= wr_req_d;
            err_q    <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.rf_rd_en   = rd_en_q;
    assign bus.rf_rd_addr = dst_q;
    assign bus.rf_wr_req  = wr_req_q;
    assign bus.rf_wr_addr = dst_q;
    assign bus.rf_wr_data = result_q;
    // A grant arriving while reset is sampled must not retire the dropped write.
    assign bus.done       = wr_req_q & bus.rf_wr_gnt & ~rst;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_byte_op_ctrl.sv
// Directed bench: one controller with 1-cycle read latency, one with 3-cycle latency.
module tb_byte_op_ctrl;
    import byte_op_pkg::*;

    logic E = 1'b0;
    always #5 E = ~E;

    logic rst1, rst3;
    byte_op_ctrl_if if1();
    byte_op_ctrl_if if3();

    byte_op_ctrl #(.RD_LAT(1)) dut1 (.E(E), .rst(rst1), .bus(if1));
    byte_op_ctrl #(.RD_LAT(3)) dut3 (.E(E), .rst(rst3), .bus(if3));

    int tests = 0;
    int fails = 0;
    int inv_bad = 0;

    logic [15:0] rf1 [8];
    logic [15:0] rf3 [8];

    // register-file read models: data appears RD_LAT cycles after the strobe
    logic       p1 = 1'b0;
    logic [2:0] a1 = '0;
    logic [2:0] p3 = '0;
    logic [2:0] a3 [3];
    always @(posedge E) begin
        p1    <= if1.rf_rd_en;
        a1    <= if1.rf_rd_addr;
        p3    <= {p3[1:0], if3.rf_rd_en};
        a3[0] <= if3.rf_rd_addr;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end
    assign if1.rf_rd_data = p1    ? rf1[a1]    : 16'hDEAD;
    assign if3.rf_rd_data = p3[2] ? rf3[a3[2]] : 16'hBEEF;

    always @(negedge E) begin
        if ((if1.done && if1.err) || (if1.rf_rd_en && if1.rf_wr_req) ||
            (if3.done && if3.err) || (if3.rf_rd_en && if3.rf_wr_req))
            inv_bad++;
    end

    task automatic issue1(input logic [2:0] op, input logic [2:0] dst, input logic [7:0] b);
        @(negedge E);
        if1.req_valid = 1'b1;
        if1.req_op    = op;
        if1.req_dst   = dst;
        if1.req_byte  = b;
        @(posedge E);
        @(negedge E);
        if1.req_valid = 1'b0;
    endtask

    task automatic issue3(input logic [2:0] op, input logic [2:0] dst, input logic [7:0] b);
        @(negedge E);
        if3.req_valid = 1'b1;
        if3.req_op    = op;
        if3.req_dst   = dst;
        if3.req_byte  = b;
        @(posedge E);
        @(negedge E);
        if3.req_valid = 1'b0;
    endtask

    task automatic wait_done1(output int cyc, output logic [15:0] data, output logic [2:0] addr);
        cyc = -1; data = 'x; addr = 'x;
        for (int c = 1; c <= 12; c++) begin
            if (if1.done === 1'b1) begin
                cyc = c; data = if1.rf_wr_data; addr = if1.rf_wr_addr;
                break;
            end
            @(negedge E);
        end
    endtask

    task automatic wait_done3(output int cyc, output logic [15:0] data, output logic [2:0] addr);
        cyc = -1; data = 'x; addr = 'x;
        for (int c = 1; c <= 14; c++) begin
            if (if3.done === 1'b1) begin
                cyc = c; data = if3.rf_wr_data; addr = if3.rf_wr_addr;
                break;
            end
            @(negedge E);
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        if1.req_valid = 0; if1.req_op = 0; if1.req_dst = 0; if1.req_byte = 0; if1.rf_wr_gnt = 0;
        if3.req_valid = 0; if3.req_op = 0; if3.req_dst = 0; if3.req_byte = 0; if3.rf_wr_gnt = 0;
        repeat (3) @(posedge E);
        @(negedge E);
        tests++;
        if ({if1.req_ready, if1.rf_rd_en, if1.rf_wr_req, if1.done, if1.err} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctrl1: got %b expected %b",
                     {if1.req_ready, if1.rf_rd_en, if1.rf_wr_req, if1.done, if1.err}, 5'b10000);
        end
        tests++;
        if ({if1.rf_wr_addr, if1.rf_rd_addr, if1.rf_wr_data} !== 22'h0) begin
            fails++;
            $display("FAIL reset_data1: got %h expected 0",
                     {if1.rf_wr_addr, if1.rf_rd_addr, if1.rf_wr_data});
        end
        tests++;
        if ({if3.req_ready, if3.rf_rd_en, if3.rf_wr_req, if3.done, if3.err, if3.rf_wr_data} !== {5'b10000, 16'h0}) begin
            fails++;
            $display("FAIL reset_3: got %b/%h expected 10000/0000",
                     {if3.req_ready, if3.rf_rd_en, if3.rf_wr_req, if3.done, if3.err}, if3.rf_wr_data);
        end
        rst1 = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_ops();
        logic [2:0]  ops  [6] = '{OP_MOVL, OP_MOVLZ, OP_MOVLS, OP_MOVH, OP_SWPB, OP_MOVH};
        logic [2:0]  dsts [6] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5};
        logic [7:0]  bs   [6] = '{8'hAB, 8'hAB, 8'hAB, 8'hAB, 8'hFF, 8'h77};
        logic [15:0] exp  [6] = '{16'h12AB, 16'h00AB, 16'hFFAB, 16'hAB34, 16'h3412, 16'h770F};
        int cyc; logic [15:0] data; logic [2:0] addr;
        if1.rf_wr_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue1(ops[i], dsts[i], bs[i]);
            tests++;
            if ({if1.rf_rd_en, if1.rf_rd_addr} !== {1'b1, dsts[i]}) begin
                fails++;
                $display("FAIL op%0d_read: got en=%b addr=%0d expected en=1 addr=%0d",
                         i, if1.rf_rd_en, if1.rf_rd_addr, dsts[i]);
            end
            wait_done1(cyc, data, addr);
            tests++;
            if (cyc !== 4) begin
                fails++;
                $display("FAIL op%0d_latency: got %0d expected 4", i, cyc);
            end
            tests++;
            if ({addr, data} !== {dsts[i], exp[i]}) begin
                fails++;
                $display("FAIL op%0d_result: got addr=%0d data=%h expected addr=%0d data=%h",
                         i, addr, data, dsts[i], exp[i]);
            end
            @(negedge E);
            tests++;
            if ({if1.req_ready, if1.done} !== 2'b10) begin
                fails++;
                $display("FAIL op%0d_ready_after: got %b expected 10", i, {if1.req_ready, if1.done});
            end
        end
    endtask

    task automatic test_illegal();
        int rd_cnt = 0, wr_cnt = 0, err_cnt = 0, done_cnt = 0, err_cyc = -1;
        logic rdy_at_err = 1'b0;
        if1.rf_wr_gnt = 1'b1;
        issue1(3'd6, 3'd3, 8'hAB);
        for (int c = 1; c <= 6; c++) begin
            if (if1.rf_rd_en)  rd_cnt++;
            if (if1.rf_wr_req) wr_cnt++;
            if (if1.done)      done_cnt++;
            if (if1.err) begin
                err_cnt++; err_cyc = c; rdy_at_err = if1.req_ready;
            end
            @(negedge E);
        end
        tests++;
        if (err_cnt !== 1 || err_cyc !== 2) begin
            fails++;
            $display("FAIL illegal_err: got count=%0d cycle=%0d expected count=1 cycle=2", err_cnt, err_cyc);
        end
        tests++;
        if ({rd_cnt, wr_cnt, done_cnt} !== {32'd0, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL illegal_quiet: got rd=%0d wr=%0d done=%0d expected 0/0/0", rd_cnt, wr_cnt, done_cnt);
        end
        tests++;
        if (rdy_at_err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_ready: got %b expected 1", rdy_at_err);
        end
    endtask

    task automatic test_grant_holdoff();
        int seen = -1, bad = 0;
        if1.rf_wr_gnt = 1'b0;
        issue1(OP_MOVL, 3'd3, 8'h55);
        for (int c = 1; c <= 10; c++) begin
            if (if1.rf_wr_req === 1'b1) begin seen = c; break; end
            @(negedge E);
        end
        tests++;
        if (seen !== 4) begin
            fails++;
            $display("FAIL holdoff_req_start: got %0d expected 4", seen);
        end
        for (int i = 0; i < 5; i++) begin
            if ({if1.rf_wr_req, if1.rf_wr_addr, if1.rf_wr_data, if1.done, if1.req_ready} !==
                {1'b1, 3'd3, 16'h1255, 1'b0, 1'b0})
                bad++;
            @(negedge E);
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL holdoff_stable: got %0d unstable cycles expected 0", bad);
        end
        if1.rf_wr_gnt = 1'b1;
        #1;
        tests++;
        if ({if1.done, if1.rf_wr_data} !== {1'b1, 16'h1255}) begin
            fails++;
            $display("FAIL holdoff_done: got done=%b data=%h expected 1/1255", if1.done, if1.rf_wr_data);
        end
        @(negedge E);
        if1.rf_wr_gnt = 1'b0;
        #1;
        tests++;
        if ({if1.done, if1.rf_wr_req, if1.req_ready} !== 3'b001) begin
            fails++;
            $display("FAIL holdoff_after: got %b expected 001", {if1.done, if1.rf_wr_req, if1.req_ready});
        end
    endtask

    task automatic test_back_to_back();
        int d1 = -1, d2 = -1;
        if1.rf_wr_gnt = 1'b1;
        @(negedge E);
        if1.req_valid = 1'b1; if1.req_op = OP_SWPB; if1.req_dst = 3'd3; if1.req_byte = 8'h00;
        for (int c = 1; c <= 20; c++) begin
            @(negedge E);
            if (if1.done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else begin d2 = c; break; end
            end
        end
        if1.req_valid = 1'b0;
        tests++;
        if (d1 !== 4 || d2 !== 9) begin
            fails++;
            $display("FAIL back_to_back: got done cycles %0d,%0d expected 4,9", d1, d2);
        end
        repeat (2) @(negedge E);
    endtask

    task automatic test_rdlat3_reset();
        int cyc, dn = 0, wr = 0, er = 0;
        logic [15:0] data; logic [2:0] addr;
        if3.rf_wr_gnt = 1'b1;
        issue3(OP_MOVL, 3'd2, 8'h11);
        wait_done3(cyc, data, addr);
        tests++;
        if (cyc !== 6 || data !== 16'hC311 || addr !== 3'd2) begin
            fails++;
            $display("FAIL lat3_movl: got cyc=%0d data=%h addr=%0d expected 6/C311/2", cyc, data, addr);
        end
        @(negedge E);
        issue3(OP_MOVL, 3'd2, 8'h22);
        @(negedge E);
        rst3 = 1'b1;
        @(negedge E);
        rst3 = 1'b0;
        tests++;
        if ({if3.req_ready, if3.rf_wr_req, if3.rf_rd_en} !== 3'b100) begin
            fails++;
            $display("FAIL lat3_reset_idle: got %b expected 100", {if3.req_ready, if3.rf_wr_req, if3.rf_rd_en});
        end
        for (int c = 0; c < 10; c++) begin
            if (if3.done)      dn++;
            if (if3.rf_wr_req) wr++;
            if (if3.err)       er++;
            @(negedge E);
        end
        tests++;
        if ({dn, wr, er} !== {32'd0, 32'd0, 32'd0}) begin
            fails++;
            $display("FAIL lat3_reset_quiet: got done=%0d wr=%0d err=%0d expected 0/0/0", dn, wr, er);
        end
        issue3(OP_MOVH, 3'd2, 8'h9E);
        wait_done3(cyc, data, addr);
        tests++;
        if (cyc !== 6 || data !== 16'h9EA5 || addr !== 3'd2) begin
            fails++;
            $display("FAIL lat3_movh: got cyc=%0d data=%h addr=%0d expected 6/9EA5/2", cyc, data, addr);
        end
        @(negedge E);
    endtask

    task automatic test_invariants();
        tests++;
        if (inv_bad !== 0) begin
            fails++;
            $display("FAIL invariants: got %0d overlapping cycles expected 0", inv_bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf1[i] = 16'h0100 * i[15:0];
            rf3[i] = 16'h0011 * i[15:0];
        end
        rf1[3] = 16'h1234;
        rf1[5] = 16'h5A0F;
        rf3[2] = 16'hC3A5;
        test_reset();
        test_ops();
        test_illegal();
        test_grant_holdoff();
        test_back_to_back();
        test_rdlat3_reset();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
